// File: rtl/tm1638_pkg.sv
// Shared constants, state type and command-word packing for the TM1638 display sequencer.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
  localparam logic [7:0] CMD_ADDR_BASE  = 8'hC0;
  localparam logic [7:0] CMD_DISP_BASE  = 8'h80;

  localparam int WORD_W       = 18;
  localparam int BIT_WRITE    = 17;
  localparam int BIT_HAS_DATA = 16;
  localparam int DATA_LSB     = 8;
  localparam int CMD_LSB      = 0;

  localparam int         BUF_DEPTH = 16;
  localparam logic [4:0] LAST_STEP = 5'd17;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [WORD_W-1:0] tm1638_word(input logic       i_Write,
                                                    input logic       i_Has_Data,
                                                    input logic [7:0] i_Data,
                                                    input logic [7:0] i_Cmd);
    logic [WORD_W-1:0] w_Word;
    w_Word                  = '0;
    w_Word[BIT_WRITE]       = i_Write;
    w_Word[BIT_HAS_DATA]    = i_Has_Data;
    w_Word[DATA_LSB +: 8]   = i_Data;
    w_Word[CMD_LSB +: 8]    = i_Cmd;
    return w_Word;
  endfunction

endpackage

// File: rtl/tm1638_display_sequencer_if.sv
// Command-word handshake between the display sequencer and the TM1638 SPI stage.
interface tm1638_display_sequencer_if;
  logic [17:0] o_Data;
  logic        o_Data_Ready;
  logic        i_SPI_Busy;

  modport master (output o_Data, output o_Data_Ready, input  i_SPI_Busy);
  modport slave  (input  o_Data, input  o_Data_Ready, output i_SPI_Busy);
endinterface

// File: rtl/tm1638_disp_buf.sv
// 16x8 display image with asynchronous read and a dirty flag that tracks unsent content.
module tm1638_disp_buf
  import tm1638_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Wr_En,
  input  logic [3:0] i_Wr_Addr,
  input  logic [7:0] i_Wr_Data,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  input  logic       i_Mark,
  input  logic       i_Clr,
  output logic       o_Dirty
);

  logic [7:0] r_Mem [BUF_DEPTH];
  logic       r_Dirty;

  // A write must never be lost by a simultaneous clear; a weak mark loses to the clear.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_Mem[i] <= 8'h00;
      r_Dirty <= 1'b1;
    end else begin
      if (i_Wr_En) r_Mem[i_Wr_Addr] <= i_Wr_Data;
      if (i_Wr_En)     r_Dirty <= 1'b1;
      else if (i_Clr)  r_Dirty <= 1'b0;
      else if (i_Mark) r_Dirty <= 1'b1;
    end
  end

  assign o_Rd_Data = r_Mem[i_Rd_Addr];
  assign o_Dirty   = r_Dirty;

endmodule

// File: rtl/tm1638_display_sequencer.sv
// Streams 18-command TM1638 frames (data cmd, 16 address writes, display control) to the SPI stage.
module tm1638_display_sequencer
  import tm1638_pkg::*;
#(
  parameter logic [15:0] STARTUP_CYCLES = 16'd1000,
  parameter bit          AUTO_REFRESH   = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Wr_En,
  input  logic [3:0] i_Wr_Addr,
  input  logic [7:0] i_Wr_Data,
  input  logic [2:0] i_Brightness,
  input  logic       i_Display_On,
  input  logic       i_Refresh,
  tm1638_display_sequencer_if.master spi,
  output logic       o_Busy,
  output logic       o_Frame_Done
);

  state_t      r_State, w_Next_State;
  logic [4:0]  r_Step, w_Next_Step;
  logic [15:0] r_Delay, w_Next_Delay;
  logic [17:0] r_Data, w_Next_Data;
  logic        r_Data_Ready, w_Next_Ready;
  logic        r_Frame_Done, w_Next_Done;
  logic [3:0]  r_Last_Ctrl, w_Next_Last_Ctrl;

  logic [3:0]  w_Ctrl;
  logic [3:0]  w_Rd_Addr;
  logic [7:0]  w_Rd_Data;
  logic [17:0] w_Word;
  logic        w_Dirty;
  logic        w_Clr_Dirty;
  logic        w_Mark_Dirty;

  assign w_Ctrl    = {i_Display_On, i_Brightness};
  assign w_Rd_Addr = r_Step[3:0] - 4'd1;

  tm1638_disp_buf u_buf (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Wr_En   (i_Wr_En),
    .i_Wr_Addr (i_Wr_Addr),
    .i_Wr_Data (i_Wr_Data),
    .i_Rd_Addr (w_Rd_Addr),
    .o_Rd_Data (w_Rd_Data),
    .i_Mark    (w_Mark_Dirty),
    .i_Clr     (w_Clr_Dirty),
    .o_Dirty   (w_Dirty)
  );

  // Buffer bytes and control settings are sampled live when each command is issued.
  always_comb begin
    if (r_Step == 5'd0)
      w_Word = tm1638_word(1'b1, 1'b0, 8'h00, CMD_DATA_FIXED);
    else if (r_Step == LAST_STEP)
      w_Word = tm1638_word(1'b1, 1'b0, 8'h00, CMD_DISP_BASE | {4'h0, w_Ctrl});
    else
      w_Word = tm1638_word(1'b1, 1'b1, w_Rd_Data, CMD_ADDR_BASE | {4'h0, w_Rd_Addr});
  end

  always_comb begin
    w_Next_State     = r_State;
    w_Next_Step      = r_Step;
    w_Next_Delay     = r_Delay;
    w_Next_Data      = r_Data;
    w_Next_Ready     = 1'b0;
    w_Next_Done      = 1'b0;
    w_Next_Last_Ctrl = r_Last_Ctrl;
    w_Clr_Dirty      = 1'b0;
    w_Mark_Dirty     = 1'b0;
    case (r_State)
      ST_STARTUP: begin
        if (r_Delay == STARTUP_CYCLES - 16'd1) w_Next_State = ST_IDLE;
        else                                   w_Next_Delay = r_Delay + 16'd1;
      end
      ST_IDLE: begin
        // Control changes only mark dirty between frames; the final command of a frame sends them anyway.
        w_Mark_Dirty = (w_Ctrl != r_Last_Ctrl);
        if ((AUTO_REFRESH && w_Dirty) || i_Refresh) begin
          w_Next_Step  = 5'd0;
          w_Clr_Dirty  = 1'b1;
          w_Next_State = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!spi.i_SPI_Busy) begin
          w_Next_Data  = w_Word;
          w_Next_Ready = 1'b1;
          w_Next_State = ST_WAIT_ACK;
          if (r_Step == LAST_STEP) w_Next_Last_Ctrl = w_Ctrl;
        end
      end
      ST_WAIT_ACK: begin
        if (spi.i_SPI_Busy) w_Next_State = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!spi.i_SPI_Busy) begin
          if (r_Step == LAST_STEP) begin
            w_Next_Done  = 1'b1;
            w_Next_State = ST_IDLE;
          end else begin
            w_Next_Step  = r_Step + 5'd1;
            w_Next_State = ST_ISSUE;
          end
        end
      end
      default: w_Next_State = ST_STARTUP;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State      <= ST_STARTUP;
      r_Step       <= 5'd0;
      r_Delay      <= 16'd0;
      r_Data       <= 18'h0;
      r_Data_Ready <= 1'b0;
      r_Frame_Done <= 1'b0;
      r_Last_Ctrl  <= 4'h0;
    end else begin
      r_State      <= w_Next_State;
      r_Step       <= w_Next_Step;
      r_Delay      <= w_Next_Delay;
      r_Data       <= w_Next_Data;
      r_Data_Ready <= w_Next_Ready;
      r_Frame_Done <= w_Next_Done;
      r_Last_Ctrl  <= w_Next_Last_Ctrl;
    end
  end

  assign spi.o_Data       = r_Data;
  assign spi.o_Data_Ready = r_Data_Ready;
  assign o_Busy           = (r_State != ST_IDLE);
  assign o_Frame_Done     = r_Frame_Done;

endmodule
